// File: rtl/sort_order_checker.sv
// sort_order_checker: 1-deep Avalon-ST slice with per-packet order/framing/length checks.
// Define SORT_CHK_SUM_EN to add the stat_sum_o packet sum output.
module sort_order_checker #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 256,
  localparam int LW         = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              stat_valid_o,
  output logic [LW-1:0]     stat_len_o,
  output logic              stat_order_err_o,
  output logic              stat_frame_err_o,
  output logic              stat_len_err_o,
`ifdef SORT_CHK_SUM_EN
  output logic [DWIDTH+LW-1:0] stat_sum_o,
`endif
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d, len_inc;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic              ord_q, ord_d;
  logic              lerr_q, lerr_d;
  logic              acc, fwd, rep;
  logic [LW-1:0]     r_len;
  logic              r_ord, r_frm, r_lerr;

  assign snk_ready_o = !src_valid_o || src_ready_i;
  assign acc         = snk_valid_i && snk_ready_o;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    prev_d  = prev_q;
    ord_d   = ord_q;
    lerr_d  = lerr_q;
    fwd     = 1'b0;
    rep     = 1'b0;
    r_len   = len_q;
    r_ord   = ord_q;
    r_frm   = 1'b0;
    r_lerr  = lerr_q;
    len_inc = (len_q == {LW{1'b1}}) ? len_q : len_q + LW'(1);
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (snk_startofpacket_i) begin
            fwd    = 1'b1;
            len_d  = LW'(1);
            prev_d = snk_data_i;
            ord_d  = 1'b0;
            lerr_d = 1'b0;
            if (snk_endofpacket_i) begin
              rep    = 1'b1;
              r_len  = LW'(1);
              r_ord  = 1'b0;
              r_lerr = 1'b0;
            end else begin
              state_d = IN_PKT;
            end
          end else begin
            rep    = 1'b1;
            r_len  = '0;
            r_ord  = 1'b0;
            r_frm  = 1'b1;
            r_lerr = 1'b0;
          end
        end
        IN_PKT: begin
          fwd = 1'b1;
          if (snk_startofpacket_i) begin
            // truncated packet is reported; this beat opens the next one
            rep    = 1'b1;
            r_frm  = 1'b1;
            len_d  = LW'(1);
            prev_d = snk_data_i;
            ord_d  = 1'b0;
            lerr_d = 1'b0;
            if (snk_endofpacket_i) state_d = IDLE;
          end else begin
            ord_d  = ord_q | (snk_data_i < prev_q);
            prev_d = snk_data_i;
            len_d  = len_inc;
            lerr_d = lerr_q | (len_inc > LW'(MAX_PKT_LEN));
            if (snk_endofpacket_i) begin
              rep     = 1'b1;
              r_len   = len_inc;
              r_ord   = ord_d;
              r_lerr  = lerr_d;
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      prev_q  <= '0;
      ord_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      ord_q   <= ord_d;
      lerr_q  <= lerr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      src_valid_o         <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
    end else if (fwd) begin
      src_valid_o         <= 1'b1;
      src_data_o          <= snk_data_i;
      src_startofpacket_o <= snk_startofpacket_i;
      src_endofpacket_o   <= snk_endofpacket_i;
    end else if (src_ready_i) begin
      src_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stat_valid_o     <= 1'b0;
      stat_len_o       <= '0;
      stat_order_err_o <= 1'b0;
      stat_frame_err_o <= 1'b0;
      stat_len_err_o   <= 1'b0;
      pkt_cnt_o        <= '0;
      err_cnt_o        <= '0;
    end else begin
      stat_valid_o <= rep;
      if (rep) begin
        stat_len_o       <= r_len;
        stat_order_err_o <= r_ord;
        stat_frame_err_o <= r_frm;
        stat_len_err_o   <= r_lerr;
        pkt_cnt_o        <= pkt_cnt_o + 16'd1;
        if ((r_ord || r_frm || r_lerr) && err_cnt_o != 16'hFFFF)
          err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

`ifdef SORT_CHK_SUM_EN
  localparam int SW = DWIDTH + LW;

  logic [SW-1:0] sum_q, sum_d, r_sum;

  always_comb begin
    sum_d = sum_q;
    r_sum = sum_q;
    if (acc) begin
      if (state_q == IDLE) begin
        sum_d = SW'(snk_data_i);
        r_sum = snk_startofpacket_i ? SW'(snk_data_i) : '0;
      end else if (snk_startofpacket_i) begin
        sum_d = SW'(snk_data_i);
      end else begin
        sum_d = sum_q + SW'(snk_data_i);
        r_sum = sum_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sum_q      <= '0;
      stat_sum_o <= '0;
    end else begin
      sum_q <= sum_d;
      if (rep) stat_sum_o <= r_sum;
    end
  end
`endif

endmodule

// File: tb/tb_sort_order_checker.sv
// tb_sort_order_checker: directed and random packets against a queue-based model.
// Built with a small MAX_PKT_LEN so oversize and length saturation are reachable.
module tb_sort_order_checker;
  localparam int DW   = 8;
  localparam int MAXL = 4;
  localparam int LW   = $clog2(MAXL) + 1;
  localparam int SW   = DW + LW;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] snk_data = '0;
  logic          snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
  logic          snk_ready;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop, src_valid, src_ready;
  logic          stat_valid;
  logic [LW-1:0] stat_len;
  logic          stat_ord, stat_frm, stat_lerr;
  logic [SW-1:0] stat_sum;
  logic [15:0]   pkt_cnt, err_cnt;

  logic rdy_rand = 1'b0, rdy_val = 1'b1, rdy_rnd = 1'b1;
  assign src_ready = rdy_rand ? rdy_rnd : rdy_val;

  int checks = 0, errors = 0;

  sort_order_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .srst_i(srst),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop),
    .snk_endofpacket_i(snk_eop), .snk_valid_i(snk_valid),
    .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop),
    .src_endofpacket_o(src_eop), .src_valid_o(src_valid),
    .src_ready_i(src_ready),
    .stat_valid_o(stat_valid), .stat_len_o(stat_len),
    .stat_order_err_o(stat_ord), .stat_frame_err_o(stat_frm),
    .stat_len_err_o(stat_lerr),
`ifdef SORT_CHK_SUM_EN
    .stat_sum_o(stat_sum),
`endif
    .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
  );

`ifndef SORT_CHK_SUM_EN
  assign stat_sum = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t       fq[$];
  int unsigned pkt[$];
  bit          in_pkt, rep_pend;
  int          e_len, pkt_m, err_m;
  bit          e_ord, e_frm, e_lerr;
  int unsigned e_sum;

  task automatic model_report(input bit frm);
    e_len  = (pkt.size() > (2**LW - 1)) ? (2**LW - 1) : pkt.size();
    e_ord  = 1'b0;
    for (int i = 1; i < pkt.size(); i++)
      if (pkt[i] < pkt[i-1]) e_ord = 1'b1;
    e_lerr = pkt.size() > MAXL;
    e_frm  = frm;
    e_sum  = 0;
    foreach (pkt[i]) e_sum += pkt[i];
    e_sum  = e_sum % (1 << SW);
    rep_pend = 1'b1;
  endtask

  task automatic model_accept(input beat_t b);
    if (!in_pkt) begin
      if (b.sop) begin
        fq.push_back(b);
        pkt = {};
        pkt.push_back(b.d);
        if (b.eop) model_report(1'b0);
        else in_pkt = 1'b1;
      end else begin
        e_len = 0; e_ord = 0; e_frm = 1; e_lerr = 0; e_sum = 0;
        rep_pend = 1'b1;
      end
    end else begin
      fq.push_back(b);
      if (b.sop) begin
        model_report(1'b1);
        pkt = {};
        pkt.push_back(b.d);
        if (b.eop) in_pkt = 1'b0;
      end else begin
        pkt.push_back(b.d);
        if (b.eop) begin
          model_report(1'b0);
          in_pkt = 1'b0;
        end
      end
    end
  endtask

  // scoreboard: slice contents, report timing/fields and counters every cycle
  always @(negedge clk) begin
    if (srst) begin
      fq = {}; pkt = {}; in_pkt = 0; rep_pend = 0; pkt_m = 0; err_m = 0;
    end else begin
      checks++;
      if (stat_valid !== rep_pend) begin
        errors++;
        $display("FAIL stat_valid got %b exp %b t=%0t", stat_valid, rep_pend, $time);
      end
      if (rep_pend) begin
        pkt_m = (pkt_m + 1) & 32'hFFFF;
        if ((e_ord || e_frm || e_lerr) && err_m < 65535) err_m++;
        checks++;
        if ({stat_len, stat_ord, stat_frm, stat_lerr} !== {LW'(e_len), e_ord, e_frm, e_lerr}) begin
          errors++;
          $display("FAIL stat_fields got len=%0d o=%b f=%b l=%b exp len=%0d o=%b f=%b l=%b t=%0t",
                   stat_len, stat_ord, stat_frm, stat_lerr, e_len, e_ord, e_frm, e_lerr, $time);
        end
`ifdef SORT_CHK_SUM_EN
        checks++;
        if (stat_sum !== SW'(e_sum)) begin
          errors++;
          $display("FAIL stat_sum got %0d exp %0d", stat_sum, e_sum);
        end
`endif
      end
      rep_pend = 1'b0;
      checks++;
      if (pkt_cnt !== 16'(pkt_m) || err_cnt !== 16'(err_m)) begin
        errors++;
        $display("FAIL counters got %0d/%0d exp %0d/%0d t=%0t", pkt_cnt, err_cnt, pkt_m, err_m, $time);
      end
      checks++;
      if (src_valid !== (fq.size() != 0)) begin
        errors++;
        $display("FAIL src_valid got %b exp %b t=%0t", src_valid, fq.size() != 0, $time);
      end else if (src_valid) begin
        checks++;
        if ({src_data, src_sop, src_eop} !== fq[0]) begin
          errors++;
          $display("FAIL src_beat got %h exp %h t=%0t", {src_data, src_sop, src_eop}, fq[0], $time);
        end
      end
      checks++;
      if (snk_ready !== (!src_valid || src_ready)) begin
        errors++;
        $display("FAIL snk_ready got %b exp %b", snk_ready, !src_valid || src_ready);
      end
      if (src_valid && src_ready && fq.size() != 0) void'(fq.pop_front());
      if (snk_valid && snk_ready) model_accept({snk_data, snk_sop, snk_eop});
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit sop, input bit eop);
    bit acc;
    int n;
    snk_data = d; snk_sop = sop; snk_eop = eop; snk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = snk_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout beat %h", d);
    end
    snk_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    srst = 1'b1;
    snk_valid = 1'b0;
    rdy_val = 1'b1;
    idle(3);
    srst = 1'b0;
    @(negedge clk);
    checks++;
    if ({src_valid, src_data, src_sop, src_eop} !== '0) begin
      errors++;
      $display("FAIL reset_src got %h exp 0", {src_valid, src_data, src_sop, src_eop});
    end
    checks++;
    if ({stat_valid, stat_len, stat_ord, stat_frm, stat_lerr, stat_sum} !== '0) begin
      errors++;
      $display("FAIL reset_stat got %h exp 0", {stat_valid, stat_len, stat_ord, stat_frm, stat_lerr});
    end
    checks++;
    if ({pkt_cnt, err_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 0", {pkt_cnt, err_cnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors;
    send(1, 1, 0); send(3, 0, 0); send(3, 0, 0); send(9, 0, 1);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt} !== {LW'(4), 3'b000, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL vec_1339 got len=%0d oel=%b%b%b cnt=%0d/%0d exp len=4 000 1/0",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt);
    end
`ifdef SORT_CHK_SUM_EN
    checks++;
    if (stat_sum !== SW'(16)) begin
      errors++;
      $display("FAIL vec_sum got %0d exp 16", stat_sum);
    end
`endif
    send(5, 1, 0); send(2, 0, 0); send(7, 0, 1);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt} !== {LW'(3), 3'b100, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL vec_527 got len=%0d oel=%b%b%b cnt=%0d/%0d exp len=3 100 2/1",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt);
    end
    send(8'hAA, 1, 1);
    checks++;
    if (stat_valid !== 1'b1 || stat_len !== LW'(1) || stat_ord !== 1'b0) begin
      errors++;
      $display("FAIL vec_single got v=%b len=%0d o=%b exp v=1 len=1 o=0", stat_valid, stat_len, stat_ord);
    end
    idle(1);
    checks++;
    if (stat_valid !== 1'b0) begin
      errors++;
      $display("FAIL vec_pulse got %b exp 0", stat_valid);
    end
    send(8'h10, 0, 0);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt, src_valid} !== {LW'(0), 3'b010, 16'd4, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL vec_stray got len=%0d oel=%b%b%b cnt=%0d/%0d sv=%b exp len=0 010 4/2 0",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt, src_valid);
    end
    send(4, 1, 0); send(6, 0, 0); send(8, 1, 0);
    checks++;
    if ({stat_valid, stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt} !== {1'b1, LW'(2), 3'b010, 16'd5, 16'd3}) begin
      errors++;
      $display("FAIL vec_trunc got v=%b len=%0d oel=%b%b%b cnt=%0d/%0d exp 1 len=2 010 5/3",
               stat_valid, stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt);
    end
    send(9, 0, 1);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt} !== {LW'(2), 3'b000, 16'd6, 16'd3}) begin
      errors++;
      $display("FAIL vec_restart got len=%0d oel=%b%b%b cnt=%0d/%0d exp len=2 000 6/3",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt);
    end
    for (int i = 0; i < 6; i++) send(8'(i + 1), i == 0, i == 5);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, err_cnt} !== {LW'(6), 3'b001, 16'd4}) begin
      errors++;
      $display("FAIL vec_oversize got len=%0d oel=%b%b%b err=%0d exp len=6 001 4",
               stat_len, stat_ord, stat_frm, stat_lerr, err_cnt);
    end
    for (int i = 0; i < 10; i++) send(8'(i), i == 0, i == 9);
    idle(2);
    checks++;
    if ({stat_len, stat_lerr, pkt_cnt} !== {LW'(7), 1'b1, 16'd8}) begin
      errors++;
      $display("FAIL vec_len_sat got len=%0d l=%b pkt=%0d exp len=7 1 8", stat_len, stat_lerr, pkt_cnt);
    end
  endtask

  task automatic test_backpressure;
    send(20, 1, 0);
    rdy_val = 1'b0;
    snk_data = 21; snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({src_valid, src_data, snk_ready} !== {1'b1, 8'd20, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold got v=%b d=%0d r=%b exp 1 20 0", src_valid, src_data, snk_ready);
      end
    end
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    send(21, 0, 0); send(22, 0, 1);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt} !== {LW'(3), 3'b000, 16'd9}) begin
      errors++;
      $display("FAIL bp_report got len=%0d oel=%b%b%b pkt=%0d exp len=3 000 9",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt);
    end
  endtask

  task automatic test_reset_midpacket;
    send(30, 1, 0); send(31, 0, 0);
    srst = 1'b1;
    idle(2);
    srst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({stat_valid, src_valid, pkt_cnt} !== 18'd0) begin
        errors++;
        $display("FAIL rst_mid got sv=%b v=%b pkt=%0d exp 0 0 0", stat_valid, src_valid, pkt_cnt);
      end
    end
    @(posedge clk);
    #1;
    send(5, 1, 0); send(6, 0, 1);
    idle(2);
    checks++;
    if ({stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt} !== {LW'(2), 3'b000, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL rst_after got len=%0d oel=%b%b%b cnt=%0d/%0d exp len=2 000 1/0",
               stat_len, stat_ord, stat_frm, stat_lerr, pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_random;
    int base, nrep, len;
    bit open, noeop;
    logic [DW-1:0] d;
    base = pkt_m;
    nrep = 0;
    open = 1'b0;
    rdy_rand = 1'b1;
    for (int p = 0; p < 60; p++) begin
      idle($urandom_range(0, 2));
      if (!open && $urandom_range(0, 7) == 0) begin
        send(8'($urandom), 0, 0);
        nrep++;
      end
      len   = $urandom_range(1, 7);
      noeop = (p < 59) && ($urandom_range(0, 5) == 0);
      if (open && len == 1) len = 2;
      d = 8'($urandom_range(0, 40));
      for (int i = 0; i < len; i++) begin
        send(d, i == 0, (i == len - 1) && !noeop);
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : d + 8'($urandom_range(0, 3));
      end
      open = noeop;
      nrep++;
    end
    rdy_rand = 1'b0;
    idle(4);
    checks++;
    if (fq.size() != 0 || pkt_m != base + nrep) begin
      errors++;
      $display("FAIL rand_drain got left=%0d reports=%0d exp left=0 reports=%0d", fq.size(), pkt_m - base, nrep);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_midpacket;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
